// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: instruction field layout,
// opcode values, the sequencer state type and an opcode classifier.
package control_sequencer_pkg;

  // Instruction field widths and bit positions inside IR.
  localparam int OPW    = 5;
  localparam int RFW    = 4;
  localparam int NREG   = 1 << RFW;
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  typedef logic [OPW-1:0] opcode_t;
  typedef logic [RFW-1:0] reg_field_t;

  // Opcode map.
  localparam opcode_t OPC_ADD  = 5'b00011;
  localparam opcode_t OPC_SUB  = 5'b00100;
  localparam opcode_t OPC_SHR  = 5'b00101;
  localparam opcode_t OPC_SHRA = 5'b00110;
  localparam opcode_t OPC_SHL  = 5'b00111;
  localparam opcode_t OPC_AND  = 5'b01000;
  localparam opcode_t OPC_OR   = 5'b01001;
  localparam opcode_t OPC_ROR  = 5'b01010;
  localparam opcode_t OPC_ROL  = 5'b01011;
  localparam opcode_t OPC_MUL  = 5'b01111;
  localparam opcode_t OPC_DIV  = 5'b10000;
  localparam opcode_t OPC_NEG  = 5'b10001;
  localparam opcode_t OPC_NOT  = 5'b10010;
  localparam opcode_t OPC_NOP  = 5'b11010;
  localparam opcode_t OPC_HALT = 5'b11011;

  // Sequencer states: fetch T0-T2, execute T3-T6.
  typedef enum logic [3:0] {
    RESET_ST,
    T0,
    T1,
    T2,
    T3,
    T4,
    T5,
    T6,
    HALT
  } state_t;

  // How an opcode is executed after fetch.
  typedef enum logic [2:0] {
    CL_ALU,     // two-source ALU op, result to Ra
    CL_UNARY,   // one-source op (neg/not), result to Ra
    CL_MULDIV,  // 64-bit result into HI/LO
    CL_NOP,     // nop and every unassigned opcode
    CL_HALT
  } op_class_t;

  function automatic op_class_t classify(input opcode_t opc);
    op_class_t cls;
    case (opc)
      OPC_ADD, OPC_SUB, OPC_SHR, OPC_SHRA, OPC_SHL,
      OPC_AND, OPC_OR, OPC_ROR, OPC_ROL:         cls = CL_ALU;
      OPC_NEG, OPC_NOT:                          cls = CL_UNARY;
      OPC_MUL, OPC_DIV:                          cls = CL_MULDIV;
      OPC_HALT:                                  cls = CL_HALT;
      default:                                   cls = CL_NOP;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/control_sequencer_reg_select_decoder.sv
// Register-file select decoder: one-hot from a register field, all zero
// when disabled. Used once for the load enables and once for the bus drives.
module reg_select_decoder
  import control_sequencer_pkg::*;
(
  input  logic [RFW-1:0]  field,
  input  logic            enable,
  output logic [NREG-1:0] sel
);

  // One-hot decode gated by enable.
  always_comb begin
    // NOTE: assigning a default before any conditional write keeps this purely combinational (no latch).
    sel = '0;
    if (enable) begin
      sel[field] = 1'b1;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hard-wired Moore control unit for the datapath. Fetch runs T0-T2, execute
// runs T3-T6 depending on the instruction class decoded from IR. Outputs are
// decoded from the state register (and the IR held by the datapath).
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic           Clock,
  input  logic           Clear,
  input  logic [31:0]    IR,
  input  logic           Stop,
  output logic           Run,
  output logic           R0in,
  output logic           R1in,
  output logic           R2in,
  output logic           R3in,
  output logic           R4in,
  output logic           R5in,
  output logic           R6in,
  output logic           R7in,
  output logic           R8in,
  output logic           R9in,
  output logic           R10in,
  output logic           R11in,
  output logic           R12in,
  output logic           R13in,
  output logic           R14in,
  output logic           R15in,
  output logic           R0out,
  output logic           R1out,
  output logic           R2out,
  output logic           R3out,
  output logic           R4out,
  output logic           R5out,
  output logic           R6out,
  output logic           R7out,
  output logic           R8out,
  output logic           R9out,
  output logic           R10out,
  output logic           R11out,
  output logic           R12out,
  output logic           R13out,
  output logic           R14out,
  output logic           R15out,
  output logic           PCin,
  output logic           IRin,
  output logic           HIin,
  output logic           LOin,
  output logic           ZHighin,
  output logic           ZLowin,
  output logic           MARin,
  output logic           MDRin,
  output logic           OutPort,
  output logic           Cin,
  output logic           Yin,
  output logic           PCout,
  output logic           HIout,
  output logic           LOout,
  output logic           ZHighout,
  output logic           ZLowout,
  output logic           InPort,
  output logic           MDRout,
  output logic           MARout,
  output logic           Cout,
  output logic           Read,
  output logic           IncPC,
  output logic [OPW-1:0] OP
);

  state_t     state;
  state_t     state_next;
  opcode_t    opcode;
  reg_field_t ra;
  reg_field_t rb;
  reg_field_t rc;
  op_class_t  op_class;
  logic       is_muldiv;
  logic       rin_en;
  logic       rout_en;
  reg_field_t rout_field;
  logic [NREG-1:0] rin_sel;
  logic [NREG-1:0] rout_sel;
  logic       unused_ir_bits;

  // Instruction fields; the low IR bits carry no information for these formats.
  assign opcode         = IR[OP_MSB:OP_LSB];
  assign ra             = IR[RA_MSB:RA_LSB];
  assign rb             = IR[RB_MSB:RB_LSB];
  assign rc             = IR[RC_MSB:RC_LSB];
  assign op_class       = classify(opcode);
  assign is_muldiv      = (op_class == CL_MULDIV);
  assign unused_ir_bits = ^IR[RC_LSB-1:0];

  // State register; Clear forces RESET_ST at once so all outputs drop without a clock.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state <= RESET_ST;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      state <= state_next;
    end
  end

  // Next-state logic; Stop matters only on the edge that ends an instruction.
  always_comb begin
    state_next = state;
    case (state)
      RESET_ST: state_next = T0;
      T0:       state_next = T1;
      T1:       state_next = T2;
      T2: begin
        case (op_class)
          CL_ALU, CL_UNARY, CL_MULDIV: state_next = T3;
          CL_HALT:                     state_next = HALT;
          default:                     state_next = Stop ? HALT : T0;
        endcase
      end
      T3:       state_next = T4;
      T4:       state_next = T5;
      T5:       state_next = is_muldiv ? T6 : (Stop ? HALT : T0);
      T6:       state_next = Stop ? HALT : T0;
      HALT:     state_next = HALT;
      default:  state_next = RESET_ST;
    endcase
  end

  // Moore output decode: every strobe is a function of the current state.
  always_comb begin
    PCin       = 1'b0;
    IRin       = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    ZHighin    = 1'b0;
    ZLowin     = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    Yin        = 1'b0;
    PCout      = 1'b0;
    HIout      = 1'b0;
    LOout      = 1'b0;
    ZHighout   = 1'b0;
    ZLowout    = 1'b0;
    MDRout     = 1'b0;
    Read       = 1'b0;
    IncPC      = 1'b0;
    OP         = '0;
    rin_en     = 1'b0;
    rout_en    = 1'b0;
    rout_field = rb;
    case (state)
      T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
      end
      T1: begin
        PCin  = 1'b1;
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        rout_en    = 1'b1;
        rout_field = rb;
        Yin        = 1'b1;
      end
      T4: begin
        rout_en    = 1'b1;
        rout_field = (op_class == CL_UNARY) ? rb : rc;
        ZLowin     = 1'b1;
        ZHighin    = is_muldiv;
        OP         = opcode;
      end
      T5: begin
        ZLowout = 1'b1;
        if (is_muldiv) begin
          LOin = 1'b1;
        end else begin
          rin_en = 1'b1;
        end
      end
      T6: begin
        ZHighout = 1'b1;
        HIin     = 1'b1;
      end
      default: ;
    endcase
  end

  assign Run     = (state != RESET_ST) && (state != HALT);
  assign OutPort = 1'b0;
  assign InPort  = 1'b0;
  assign MARout  = 1'b0;
  assign Cin     = 1'b0;
  assign Cout    = 1'b0;

  reg_select_decoder u_rin_dec (
    .field  (ra),
    .enable (rin_en),
    .sel    (rin_sel)
  );

  reg_select_decoder u_rout_dec (
    .field  (rout_field),
    .enable (rout_en),
    .sel    (rout_sel)
  );

  assign {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
          R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in} = rin_sel;
  assign {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
          R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out} = rout_sel;

endmodule
